hilo_muldiv_unit: RTL and testbench

- Multi-cycle multiply/divide engine that owns the architectural HI/LO registers.
- It is the write side of HI/LO for MULT/MULTU/DIV/DIVU. It also serves MTHI/MTLO writes and MFHI/MFLO reads.
- Sits beside the single-cycle ALU in the execute stage. The controller issues a start pulse and stalls on busy. Results are read through hi/lo.

---
 rtl/hilo_muldiv_unit.sv | 170 +++++++++++++++++
 tb/tb_hilo_muldiv_unit.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/hilo_muldiv_unit.sv
// Purpose : multi-cycle MULT/MULTU/DIV/DIVU engine owning the HI/LO registers, plus MTHI/MTLO writes.
// Latency : WIDTH+1 edges from accepted start to HI/LO update; done pulses the cycle after.
// Backpr. : none; busy is high while an operation runs and start/MTHI/MTLO are ignored then.
module hilo_muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] reg_a,
  input  logic [WIDTH-1:0] reg_b,
  input  logic             mthi_en,
  input  logic             mtlo_en,
  input  logic [WIDTH-1:0] wr_data,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam int W2 = 2 * WIDTH;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DIV  = 2'd2,
    S_FIX  = 2'd3
  } state_t;

  state_t state, state_nxt;

  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] acc_hi;   // product high half / partial remainder
  logic [WIDTH-1:0] acc_lo;   // product low half+multiplier / dividend+quotient
  logic [WIDTH-1:0] opb;      // multiplicand / divisor magnitude
  logic             is_div;
  logic             neg_a;
  logic             neg_b;
  logic             b_zero;

  logic             in_neg_a, in_neg_b;
  logic [WIDTH-1:0] mag_a, mag_b;
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   div_shift, div_diff;
  logic             div_ge;
  logic [W2-1:0]    prod, prod_neg;
  logic [WIDTH-1:0] fix_hi, fix_lo;
  logic             iter_last;

  // Operand magnitudes and sign flags; signed ops are those with op[0] set.
  always_comb begin
    in_neg_a = op[0] & reg_a[WIDTH-1];
    in_neg_b = op[0] & reg_b[WIDTH-1];
    mag_a    = in_neg_a ? (~reg_a + WIDTH'(1)) : reg_a;
    mag_b    = in_neg_b ? (~reg_b + WIDTH'(1)) : reg_b;
  end

  // One shift-add multiply step and one restoring divide step.
  always_comb begin
    mul_sum   = {1'b0, acc_hi} + {1'b0, (acc_lo[0] ? opb : '0)};
    div_shift = {acc_hi, acc_lo[WIDTH-1]};
    div_diff  = div_shift - {1'b0, opb};
    div_ge    = ~div_diff[WIDTH];
    iter_last = (cnt == CW'(WIDTH - 1));
  end

  // Sign correction of the raw magnitude result, applied in FIX.
  always_comb begin
    prod     = {acc_hi, acc_lo};
    prod_neg = ~prod + W2'(1);
    fix_hi   = acc_hi;
    fix_lo   = acc_lo;
    if (!is_div) begin
      {fix_hi, fix_lo} = (neg_a ^ neg_b) ? prod_neg : prod;
    end else begin
      // Remainder carries the dividend sign; for divide-by-zero this restores raw reg_a.
      fix_hi = neg_a ? (~acc_hi + WIDTH'(1)) : acc_hi;
      if (b_zero)
        fix_lo = '1;
      else
        fix_lo = (neg_a ^ neg_b) ? (~acc_lo + WIDTH'(1)) : acc_lo;
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // Next-state: IDLE -> MUL/DIV on start, WIDTH iterations, then one FIX cycle.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:       if (start) state_nxt = op[1] ? S_DIV : S_MUL;
      S_MUL, S_DIV: if (iter_last) state_nxt = S_FIX;
      S_FIX:        state_nxt = S_IDLE;
      default:      state_nxt = S_IDLE;
    endcase
  end

  // Outputs derived from state.
  always_comb begin
    busy = (state != S_IDLE);
  end

  // Operand capture and iteration datapath.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt    <= '0;
      acc_hi <= '0;
      acc_lo <= '0;
      opb    <= '0;
      is_div <= 1'b0;
      neg_a  <= 1'b0;
      neg_b  <= 1'b0;
      b_zero <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            cnt    <= '0;
            acc_hi <= '0;
            acc_lo <= mag_a;
            opb    <= mag_b;
            is_div <= op[1];
            neg_a  <= in_neg_a;
            neg_b  <= in_neg_b;
            b_zero <= (reg_b == '0);
          end
        end
        S_MUL: begin
          acc_hi <= mul_sum[WIDTH:1];
          acc_lo <= {mul_sum[0], acc_lo[WIDTH-1:1]};
          cnt    <= cnt + CW'(1);
        end
        S_DIV: begin
          acc_hi <= div_ge ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0];
          acc_lo <= {acc_lo[WIDTH-2:0], div_ge};
          cnt    <= cnt + CW'(1);
        end
        default: ;
      endcase
    end
  end

  // HI/LO: result load in FIX, MTHI/MTLO only while idle, otherwise hold.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hi          <= '0;
      lo          <= '0;
      done        <= 1'b0;
      div_by_zero <= 1'b0;
    end else begin
      done        <= (state == S_FIX);
      div_by_zero <= (state == S_FIX) && is_div && b_zero;
      if (state == S_FIX) begin
        hi <= fix_hi;
        lo <= fix_lo;
      end else if (state == S_IDLE) begin
        if (mthi_en) hi <= wr_data;
        if (mtlo_en) lo <= wr_data;
      end
    end
  end

endmodule

// File: tb/tb_hilo_muldiv_unit.sv
// Purpose : scoreboard bench for hilo_muldiv_unit with directed, hand-computed vectors.
// Latency : expects done exactly 33 edges after the start edge (WIDTH=32).
// Backpr. : exercises start/MTHI while busy, MT in done cycle, async reset mid-operation.
module tb_hilo_muldiv_unit;

  localparam int W = 32;

  logic         clk     = 1'b0;
  logic         rst_n   = 1'b0;
  logic         start   = 1'b0;
  logic [1:0]   op      = 2'b00;
  logic [W-1:0] reg_a   = '0;
  logic [W-1:0] reg_b   = '0;
  logic         mthi_en = 1'b0;
  logic         mtlo_en = 1'b0;
  logic [W-1:0] wr_data = '0;
  logic         busy, done, div_by_zero;
  logic [W-1:0] hi, lo;

  hilo_muldiv_unit #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .op          (op),
    .reg_a       (reg_a),
    .reg_b       (reg_b),
    .mthi_en     (mthi_en),
    .mtlo_en     (mtlo_en),
    .wr_data     (wr_data),
    .busy        (busy),
    .done        (done),
    .div_by_zero (div_by_zero),
    .hi          (hi),
    .lo          (lo)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct packed {
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic         dbz;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   t0       = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: every done pulse pops one expected result and compares.
  always @(negedge clk) begin : monitor
    exp_t e;
    if (done === 1'b1) begin
      if (sb.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_done: got done=1 at cycle %0d, expected no pending result", cyc);
      end else begin
        e = sb.pop_front();
        check("result_hi", 64'(hi), 64'(e.hi));
        check("result_lo", 64'(lo), 64'(e.lo));
        check("result_dbz", 64'(div_by_zero), 64'(e.dbz));
        check("busy_in_done_cycle", 64'(busy), 64'd0);
      end
    end else if (div_by_zero === 1'b1) begin
      check("stray_dbz", 64'(div_by_zero), 64'd0);
    end
  end

  // Drive one start for one edge; optionally queue the expected result.
  task automatic issue(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                       input bit push, input logic [W-1:0] ehi, input logic [W-1:0] elo,
                       input logic edbz);
    exp_t e;
    op    = o;
    reg_a = a;
    reg_b = b;
    start = 1'b1;
    if (push) begin
      e.hi  = ehi;
      e.lo  = elo;
      e.dbz = edbz;
      sb.push_back(e);
    end
    @(posedge clk);
    #1;
    t0    = cyc;
    start = 1'b0;
    reg_a = 32'hDEADBEEF;
    reg_b = 32'h00000001;
  endtask

  // Wait (bounded) for done; check busy stayed high and the latency is WIDTH+1.
  task automatic wait_done();
    bit seen = 0;
    bit all_busy = 1;
    int lat;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        seen = 1;
        break;
      end
      if (busy !== 1'b1) all_busy = 0;
    end
    lat = seen ? (cyc - t0) : -1;
    check("done_latency", 64'(lat), 64'd33);
    check("busy_until_done", 64'(all_busy), 64'd1);
  endtask

  initial begin
    // Reset state
    repeat (2) @(negedge clk);
    check("reset_hi", 64'(hi), 64'd0);
    check("reset_lo", 64'(lo), 64'd0);
    check("reset_busy", 64'(busy), 64'd0);
    check("reset_done", 64'(done), 64'd0);
    check("reset_dbz", 64'(div_by_zero), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // MULTU max * max
    issue(2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 1, 32'hFFFFFFFE, 32'h00000001, 1'b0);
    wait_done();
    // MULT -3 * 7
    issue(2'b01, 32'hFFFFFFFD, 32'd7, 1, 32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0);
    wait_done();
    // DIV -7 / 2
    issue(2'b11, 32'hFFFFFFF9, 32'd2, 1, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0);
    wait_done();
    // DIVU 100 / 7
    issue(2'b10, 32'd100, 32'd7, 1, 32'd2, 32'd14, 1'b0);
    wait_done();
    // DIVU by zero
    issue(2'b10, 32'h12345678, 32'd0, 1, 32'h12345678, 32'hFFFFFFFF, 1'b1);
    wait_done();
    // DIV most-negative / -1
    issue(2'b11, 32'h80000000, 32'hFFFFFFFF, 1, 32'h00000000, 32'h80000000, 1'b0);
    wait_done();

    // MULTU 6*7 with MTHI and a second start while busy
    issue(2'b00, 32'd6, 32'd7, 1, 32'd0, 32'd42, 1'b0);
    repeat (4) @(negedge clk);
    wr_data = 32'hAAAA5555;
    mthi_en = 1'b1;
    @(negedge clk);
    mthi_en = 1'b0;
    check("mthi_busy_ignored", 64'(hi), 64'd0);
    check("lo_held_during_op", 64'(lo), 64'h80000000);
    check("busy_mid_op", 64'(busy), 64'd1);
    repeat (5) @(negedge clk);
    op    = 2'b10;
    reg_a = 32'd1;
    reg_b = 32'd1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done();

    // MTLO in the done cycle
    wr_data = 32'h0BADF00D;
    mtlo_en = 1'b1;
    @(negedge clk);
    mtlo_en = 1'b0;
    check("mtlo_lo", 64'(lo), 64'h0BADF00D);
    check("mtlo_hi_unchanged", 64'(hi), 64'd0);

    // MTHI and MTLO together
    wr_data = 32'h11112222;
    mthi_en = 1'b1;
    mtlo_en = 1'b1;
    @(negedge clk);
    mthi_en = 1'b0;
    mtlo_en = 1'b0;
    check("mt_both_hi", 64'(hi), 64'h11112222);
    check("mt_both_lo", 64'(lo), 64'h11112222);

    // MTHI coincident with an accepted start: applied, then overwritten by the result
    wr_data = 32'hDEAD0000;
    mthi_en = 1'b1;
    issue(2'b00, 32'd2, 32'd3, 1, 32'd0, 32'd6, 1'b0);
    mthi_en = 1'b0;
    @(negedge clk);
    check("mt_with_start_hi", 64'(hi), 64'hDEAD0000);
    check("mt_with_start_lo", 64'(lo), 64'h11112222);
    wait_done();

    // Asynchronous reset in the middle of a MULT; no result may appear
    issue(2'b01, 32'hFFFFFFFD, 32'd7, 0, '0, '0, 1'b0);
    repeat (15) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("arst_hi", 64'(hi), 64'd0);
    check("arst_lo", 64'(lo), 64'd0);
    check("arst_busy", 64'(busy), 64'd0);
    check("arst_done", 64'(done), 64'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (45) @(negedge clk);
    check("post_reset_idle", 64'(busy), 64'd0);

    // Fresh MULTU after reset
    issue(2'b00, 32'd3, 32'd5, 1, 32'd0, 32'd15, 1'b0);
    wait_done();
    @(negedge clk);

    check("scoreboard_drained", 64'(sb.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
